// File: rtl/spi_adc_emu.sv
// -----------------------------------------------------------------------------
// spi_adc_emu
// SPI slave that behaves like a simple multi-channel serial ADC, so an on-chip
// SPI master can be exercised in loopback. Every frame shifts out the sample
// counter of the selected channel, MSB first, zero-padded to FRAME_W bits.
// Each complete frame advances that channel's counter by STEP (mod 2^DATA_W).
// The first CH_W bits received on sdi choose the channel for the next frame.
//
// Ports
//   clk        system clock (sclk must be at most clk/8)
//   resetb     asynchronous active-low reset
//   sclk       SPI clock, asynchronous to clk
//   csb        SPI chip select, active low, asynchronous
//   sdi        SPI data in (channel select for the next frame)
//   sdo        SPI data out
//   sdo_oe     pad output enable for sdo (1 = drive)
//   ld_valid   one-cycle preload strobe
//   ld_ch      channel to preload (values >= N_CH are ignored)
//   ld_value   value to preload
//   frame_done one-cycle pulse per complete frame
//   cur_ch     channel of the current / most recent frame
// -----------------------------------------------------------------------------
module spi_adc_emu #(
    parameter int DATA_W  = 12,
    parameter int FRAME_W = 16,
    parameter int N_CH    = 2,
    parameter int STEP    = 3,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sclk,
    input  logic              csb,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic              ld_valid,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [DATA_W-1:0] ld_value,
    output logic              frame_done,
    output logic [CH_W-1:0]   cur_ch
);

    localparam int BC_W = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_OVER} state_t;

    // Two synchroniser flops plus one history flop for edge detection.
    // Reset to the idle pin levels so reset release creates no false edges.
    logic [2:0] sclk_q;
    logic [2:0] csb_q;
    logic [1:0] sdi_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sclk_q <= {3{CPOL}};
            csb_q  <= 3'b111;
            sdi_q  <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            csb_q  <= {csb_q[1:0], csb};
            sdi_q  <= {sdi_q[0], sdi};
        end
    end

    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, launch_edge, csb_fall, csb_rise;

    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign launch_edge = CPHA ? lead_edge : trail_edge;
    assign csb_fall    = csb_q[2] & ~csb_q[1];
    assign csb_rise    = ~csb_q[2] & csb_q[1];

    // Frame state
    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic [CH_W-1:0]     rxsh_q, rxsh_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]     next_ch_q, next_ch_d;
    logic                sdo_q, sdo_d;
    logic                oe_q, oe_d;
    logic                done_q, done_d;
    logic                inc;

    // Per-channel sample counters
    logic [N_CH-1:0][DATA_W-1:0] cnt_vec;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    cnt_q <= '0;
                end else if (ld_valid && ld_ch == CH_W'(gi)) begin
                    // A preload takes priority over a coincident increment.
                    cnt_q <= ld_value;
                end else if (inc && cur_ch_q == CH_W'(gi)) begin
                    cnt_q <= cnt_q + DATA_W'(STEP);
                end
            end
            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    logic [FRAME_W-1:0] load_word;
    assign load_word = FRAME_W'(cnt_vec[next_ch_q]);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        rxsh_d    = rxsh_q;
        cur_ch_d  = cur_ch_q;
        next_ch_d = next_ch_q;
        sdo_d     = sdo_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        inc       = 1'b0;

        if (state_q != S_IDLE && csb_rise) begin
            // Deselect aborts whatever is in progress; a frame that has not
            // reached FRAME_W sample edges leaves counters and next_ch alone.
            state_d = S_IDLE;
            sdo_d   = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csb_fall) begin
                        state_d  = S_LOAD;
                        shreg_d  = load_word;
                        cur_ch_d = next_ch_q;
                        bitcnt_d = '0;
                        rxsh_d   = '0;
                        oe_d     = 1'b1;
                        // Mode with CPHA=0 needs the MSB on the wire before
                        // the first (sampling) edge.
                        sdo_d    = CPHA ? 1'b0 : load_word[FRAME_W-1];
                    end
                end
                S_LOAD: begin
                    state_d = S_SHIFT;
                end
                S_SHIFT, S_DONE, S_OVER: begin
                    if (state_q == S_DONE) begin
                        state_d = S_OVER;
                    end
                    if (launch_edge) begin
                        if (CPHA) begin
                            // MSB goes out on the first leading edge.
                            sdo_d   = shreg_q[FRAME_W-1];
                            shreg_d = shreg_q << 1;
                        end else begin
                            shreg_d = shreg_q << 1;
                            sdo_d   = shreg_d[FRAME_W-1];
                        end
                    end
                    if (sample_edge && state_q == S_SHIFT) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q < BC_W'(CH_W)) begin
                            rxsh_d = CH_W'({rxsh_q, sdi_q[1]});
                        end
                        if (bitcnt_q == BC_W'(FRAME_W - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            inc     = 1'b1;
                            if (N_CH > 1 && int'(rxsh_d) < N_CH) begin
                                next_ch_d = rxsh_d;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            rxsh_q    <= '0;
            cur_ch_q  <= '0;
            next_ch_q <= '0;
            sdo_q     <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            rxsh_q    <= rxsh_d;
            cur_ch_q  <= cur_ch_d;
            next_ch_q <= next_ch_d;
            sdo_q     <= sdo_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
        end
    end

    assign sdo        = sdo_q;
    assign sdo_oe     = oe_q;
    assign frame_done = done_q;
    assign cur_ch     = cur_ch_q;

endmodule
